// File: rtl/grant_txn_pkg.sv
// Shared types and default sizing for the grant transaction controller.
// Optional one-hot grant checking is enabled by defining GRANT_TXN_ONEHOT_CHECK_EN.
package grant_txn_pkg;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int LW   = 4;
    localparam int ID_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary index encoder; the lowest set bit wins when several are set.
module onehot_enc #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    oh_i,
    output logic [ID_W-1:0] idx_o,
    output logic            onehot_ok
);

    // Scan from the top down so the lowest set bit is the last to overwrite idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (oh_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign onehot_ok = (oh_i != '0) && ((oh_i & (oh_i - 1'b1)) == '0);

endmodule

// File: rtl/grant_txn_ctrl.sv
// Locks an arbiter grant, streams len+1 beats of that requester's payload, then acks it.
// Define GRANT_TXN_ONEHOT_CHECK_EN to flag (and ignore) non-one-hot grants via a sticky err.
module grant_txn_ctrl #(
    parameter int N  = grant_txn_pkg::N,
    parameter int DW = grant_txn_pkg::DW,
    parameter int LW = grant_txn_pkg::LW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         grant,
    input  logic [N*DW-1:0]      data,
    input  logic [N*LW-1:0]      len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_id,
    output logic                 out_last,
    output logic [N-1:0]         ack,
    output logic                 err
);

    import grant_txn_pkg::*;

    localparam int SEL_W = $clog2(N);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]  encIdx;
    logic              grantOk;
    logic              grantLegal;
    logic [LW-1:0]     grantLen;
    logic              inBurst;

    onehot_enc #(
        .N    (N),
        .ID_W (SEL_W)
    ) u_enc (
        .oh_i      (grant),
        .idx_o     (encIdx),
        .onehot_ok (grantOk)
    );

    assign grantLen = len[encIdx*LW +: LW];

`ifdef GRANT_TXN_ONEHOT_CHECK_EN
    logic err_q, err_d;

    assign grantLegal = grantOk;
    assign err        = err_q;
`else
    logic unused_grant_ok;

    assign unused_grant_ok = grantOk;
    assign grantLegal      = (grant != '0);
    assign err             = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
`ifdef GRANT_TXN_ONEHOT_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grantLegal) begin
                    sel_d   = encIdx;
                    cnt_d   = grantLen;
                    state_d = BURST;
                end
`ifdef GRANT_TXN_ONEHOT_CHECK_EN
                else if (grant != '0) begin
                    err_d = 1'b1;
                end
`endif
            end
            // out_valid is always high here, so out_ready alone completes a beat.
            BURST: begin
                if (out_ready) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
`ifdef GRANT_TXN_ONEHOT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
`ifdef GRANT_TXN_ONEHOT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode registered state only; out_data is the live payload of the locked requester.
    assign inBurst   = (state_q == BURST);
    assign out_valid = inBurst;
    assign out_last  = inBurst && (cnt_q == '0);
    assign out_id    = inBurst ? sel_q : '0;
    assign out_data  = inBurst ? data[sel_q*DW +: DW] : '0;
    assign ack       = (state_q == DONE) ? ({{(N-1){1'b0}}, 1'b1} << sel_q) : '0;

endmodule

// File: tb/tb_grant_txn_ctrl.sv
// Self-checking bench for grant_txn_ctrl: directed scenarios then randomized traffic vs a beat-counting model.
module tb_grant_txn_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  grant;
    logic [31:0] data;
    logic [15:0] len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic [3:0]  ack;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Model: beats still owed in the current burst, whether an ack is due, and the locked requester.
    int mBeats   = 0;
    bit mAckDue  = 0;
    int mSel     = 0;
    bit mErr     = 0;

    grant_txn_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .grant     (grant),
        .data      (data),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .ack       (ack),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] g, input logic [15:0] l, input logic [31:0] d, input logic r);
        grant     = g;
        len       = l;
        data      = d;
        out_ready = r;
    endtask

    task automatic modelReset();
        mBeats  = 0;
        mAckDue = 0;
        mSel    = 0;
        mErr    = 0;
    endtask

    task automatic modelTake();
        int g;
        g      = int'(grant);
        mSel   = $clog2(g & -g);
        mBeats = ((int'(len) >> (mSel * 4)) & 15) + 1;
    endtask

    task automatic modelEdge();
        if (!rst) begin
            modelReset();
        end else if (mAckDue) begin
            mAckDue = 0;
        end else if (mBeats > 0) begin
            if (out_ready) begin
                mBeats--;
                if (mBeats == 0) mAckDue = 1;
            end
        end else if (grant != 4'b0) begin
`ifdef GRANT_TXN_ONEHOT_CHECK_EN
            if ($countones(grant) != 1) mErr = 1;
            else modelTake();
`else
            modelTake();
`endif
        end
    endtask

    task automatic compareAll();
        checkOutput("valid", out_valid, mBeats > 0);
        checkOutput("last", out_last, mBeats == 1);
        if (mBeats > 0) begin
            checkOutput("data", out_data, (data >> (mSel * 8)) & 32'hff);
            checkOutput("id", out_id, mSel);
        end
        checkOutput("ack", ack, mAckDue ? (32'd1 << mSel) : 32'd0);
        checkOutput("err", err, mErr);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    initial begin
        logic [3:0] g;
        int         pick;

        rst = 1'b0;
        applyStimulus(4'b0, 16'h0, 32'h0, 1'b0);
        repeat (2) tick();
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_id", out_id, 0);
        rst = 1'b1;
        tick();

        // Three beats of A5 from requester 3.
        applyStimulus(4'b1000, 16'h2000, 32'hA500_0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 16'h2000, 32'hA500_0000, 1'b1);
        repeat (5) tick();

        // Single-beat burst from requester 0.
        applyStimulus(4'b0001, 16'h0000, 32'h0000_003C, 1'b1);
        tick();
        applyStimulus(4'b0000, 16'h0000, 32'h0000_003C, 1'b1);
        repeat (3) tick();

        // Backpressure held for four cycles on beat 2.
        applyStimulus(4'b0010, 16'h0030, 32'h0000_5A00, 1'b1);
        tick();
        applyStimulus(4'b0000, 16'h0030, 32'h0000_5A00, 1'b1);
        tick();
        applyStimulus(4'b0000, 16'h0030, 32'h0000_5A00, 1'b0);
        repeat (4) tick();
        applyStimulus(4'b0000, 16'h0030, 32'h0000_5A00, 1'b1);
        repeat (5) tick();

        // Grant moves from id 2 to id 1 mid-burst.
        applyStimulus(4'b0100, 16'h0100, 32'h0033_2200, 1'b1);
        tick();
        applyStimulus(4'b0010, 16'h0100, 32'h0033_2200, 1'b1);
        repeat (6) tick();
        applyStimulus(4'b0000, 16'h0100, 32'h0033_2200, 1'b1);
        repeat (2) tick();

        // Multi-hot grant.
        applyStimulus(4'b0110, 16'h0000, 32'h0011_2233, 1'b1);
        tick();
        applyStimulus(4'b0000, 16'h0000, 32'h0011_2233, 1'b1);
        repeat (4) tick();

        // Asynchronous reset during beat 2 of a six-beat burst.
        applyStimulus(4'b0001, 16'h0005, 32'h0000_0077, 1'b1);
        tick();
        applyStimulus(4'b0000, 16'h0005, 32'h0000_0077, 1'b1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        compareAll();
        checkOutput("rst_mid_data", out_data, 0);
        checkOutput("rst_mid_id", out_id, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

        // Randomized traffic, including all-ones lengths and occasional multi-hot grants.
        for (int i = 0; i < 800; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4) g = 4'b0;
            else if (pick < 8) g = 4'b1 << $urandom_range(0, 3);
            else g = 4'($urandom_range(0, 15));
            applyStimulus(g, 16'($urandom), $urandom, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grant_txn_ctrl.md
# grant_txn_ctrl

Downstream consumer of the 4-way fixed-priority arbiter's one-hot `grant`. Locks the granted requester, muxes its payload onto a single shared output channel for a burst of beats under a valid/ready handshake, and pulses a per-requester `ack` when the burst ends. The arbiter may change `grant` freely mid-burst; this block ignores it until it returns to IDLE.

## Interface
- `N`, 4: number of requesters; width of `grant` and `ack`.
- `DW`, 8: payload width per requester.
- `LW`, 4: burst-length field width; the burst is `len + 1` beats.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low; assert 0 to clear.
- `grant` input N: one-hot grant from the arbiter.
- `data` input N*DW: packed payloads; requester i occupies bits `[i*DW +: DW]`.
- `len` input N*LW: packed burst lengths; requester i occupies bits `[i*LW +: LW]`.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: downstream accepts a beat.
- `out_data` output DW: payload of the locked requester.
- `out_id` output clog2(N): index of the locked requester.
- `out_last` output 1: marks the final beat of the burst.
- `ack` output N: one-cycle pulse to the requester whose burst has completed.
- `err` output 1: sticky flag; set on an illegal grant.

## Operation
- States: IDLE, BURST, DONE.
- IDLE:
  - `grant` is sampled every cycle.
  - If `grant` is nonzero and legal: latch `sel` (encoded index) and `cnt = len[sel]`, then go to BURST.
  - If `grant` is zero: stay in IDLE.
- BURST:
  - `out_valid` = 1, `out_data` = `data[sel]` (live, not latched), `out_id` = `sel`.
  - `out_last` = (`cnt` == 0).
  - On `out_valid && out_ready`:
    - If `cnt` == 0: go to DONE.
    - Otherwise: decrement `cnt`.
  - With `out_ready` low, the beat holds unchanged and `cnt` holds.
- DONE: `ack[sel]` = 1 for exactly one cycle, `out_valid` = 0, then go to IDLE.
- Grant lock: `grant` changes during BURST/DONE are ignored and cause no `err`.
- `len` = 0 gives a single-beat burst with `out_last` high on that beat.
- `len` = all-ones gives 2^LW beats; `cnt` never wraps because the exit happens at 0.
- Simultaneous grant and DONE: no new grant is taken in DONE. A grant still present in the following IDLE cycle is taken then, so back-to-back bursts are separated by one IDLE cycle.
- Reset mid-burst: immediate return to IDLE. The partial burst is dropped and no `ack` is issued.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_id` 0, `out_last` 0, `ack` 0, `err` 0, state IDLE, `cnt` 0, `sel` 0.
- Latency:
  - Grant seen in IDLE at edge k → first beat valid in cycle k+1.
  - Last beat accepted at edge m → `ack` high in cycle m+1 → IDLE in cycle m+2.
- Minimum burst occupancy: `len + 3` cycles from grant sample to the next IDLE, with `out_ready` held high.
- All outputs are registered or decoded from registered state; there is no combinational path from `grant` to `out_*`.
- `out_data` follows `data[sel]` combinationally through the mux.

## Configuration
- `GRANT_TXN_ONEHOT_CHECK_EN` defined:
  - A non-one-hot, nonzero `grant` in IDLE sets `err`.
  - `err` stays set until reset.
  - The grant is ignored and the block stays in IDLE.
- `GRANT_TXN_ONEHOT_CHECK_EN` undefined:
  - The lowest set bit of `grant` is taken as `sel`.
  - `err` is tied to 0.

## Structure
- Package `grant_txn_pkg`: state enum (IDLE/BURST/DONE), default constants `N`, `DW`, `LW`, and the `ID_W = clog2(N)` helper.
- Sub-module `onehot_enc`:
  - Converts one-hot to binary index with lowest-bit priority.
  - Provides a `onehot_ok` output used only when the check macro is defined.

## Test plan
- Reset then `grant` = 4'b1000, `len[3]` = 2, `data[3]` = 8'hA5, `out_ready` = 1 → three beats of A5 with `out_id` = 3, `out_last` on the 3rd beat, `ack` = 4'b1000 one cycle later.
- `grant` = 4'b0001, `len[0]` = 0 → single beat with `out_last` = 1, then `ack[0]` pulse; total occupancy of 3 cycles.
- Mid-burst backpressure: `out_ready` low for 4 cycles on beat 2 → `out_valid` stays 1 with data/`out_last` stable, and the beat count is unchanged.
- Grant switches 4'b0100 → 4'b0010 during BURST → burst completes for id 2 only. `ack` = 4'b0100, then id 1 is served after one IDLE cycle.
- With `GRANT_TXN_ONEHOT_CHECK_EN`: `grant` = 4'b0110 → `err` = 1, no `out_valid`. Without the macro: serves id 1 and `err` stays 0.
- Reset (`rst` = 0) asserted during beat 2 of a `len` = 5 burst → all outputs go to 0 immediately, no `ack`, state IDLE after release.
